// File: rtl/axi4_ar_delay_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi4_ar_delay_fifo
// Description : AXI4 read-address channel delay FIFO. Accepts AR requests,
//               adds a fixed offset to the address and holds each request
//               for a per-request latency before forwarding it. Requests
//               are always forwarded in acceptance order.
// Ports       : axi4_aclk / axi4_arstn  - clock, async active-low reset
//               s_axi4_ar*              - slave AR channel (requests in)
//               m_axi4_ar*              - master AR channel (requests out)
//               cfg_lat                 - delay in cycles, sampled on accept
//               occupancy               - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_ar_delay_fifo #(
    parameter int                    AXI_ID_WIDTH   = 4,
    parameter int                    AXI_USER_WIDTH = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DEPTH          = 8,
    parameter int                    LAT_WIDTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET    = 'h1000
) (
    input  logic                          axi4_aclk,
    input  logic                          axi4_arstn,
    // slave AR channel
    input  logic [AXI_ID_WIDTH-1:0]       s_axi4_arid,
    input  logic [ADDR_WIDTH-1:0]         s_axi4_araddr,
    input  logic [7:0]                    s_axi4_arlen,
    input  logic [2:0]                    s_axi4_arsize,
    input  logic [1:0]                    s_axi4_arburst,
    input  logic                          s_axi4_arlock,
    input  logic [2:0]                    s_axi4_arprot,
    input  logic [3:0]                    s_axi4_arcache,
    input  logic [AXI_USER_WIDTH-1:0]     s_axi4_aruser,
    input  logic                          s_axi4_arvalid,
    output logic                          s_axi4_arready,
    // master AR channel
    output logic [AXI_ID_WIDTH-1:0]       m_axi4_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi4_araddr,
    output logic [7:0]                    m_axi4_arlen,
    output logic [2:0]                    m_axi4_arsize,
    output logic [1:0]                    m_axi4_arburst,
    output logic                          m_axi4_arlock,
    output logic [2:0]                    m_axi4_arprot,
    output logic [3:0]                    m_axi4_arcache,
    output logic [AXI_USER_WIDTH-1:0]     m_axi4_aruser,
    output logic                          m_axi4_arvalid,
    input  logic                          m_axi4_arready,
    // configuration / status
    input  logic [LAT_WIDTH-1:0]          cfg_lat,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_occ_w = $clog2(DEPTH+1);
    localparam int c_pw    = AXI_ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 3 + 4
                           + AXI_USER_WIDTH;

    // storage
    logic [c_pw-1:0]      r_mem [DEPTH];
    logic [LAT_WIDTH-1:0] r_cnt [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_occ_w-1:0]   r_occ;
    logic                 r_s_ready;
    logic                 r_m_valid;
    logic [c_pw-1:0]      r_m_payload;

    // next-state
    logic [LAT_WIDTH-1:0] w_cnt_next [DEPTH];
    logic [DEPTH-1:0]     w_vld_next;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ptr_w-1:0]   w_rd_next;
    logic [c_occ_w-1:0]   w_occ_next;
    logic [LAT_WIDTH-1:0] w_lat_load;
    logic [ADDR_WIDTH-1:0] w_addr_sum;
    logic [c_pw-1:0]      w_s_payload;
    logic [c_pw-1:0]      w_head_payload;
    logic                 w_m_valid_next;

    assign w_push     = s_axi4_arvalid & r_s_ready;
    assign w_pop      = r_m_valid & m_axi4_arready;
    assign w_rd_next  = r_rd_ptr + c_ptr_w'(w_pop);
    assign w_occ_next = r_occ + c_occ_w'(w_push) - c_occ_w'(w_pop);

    // max(cfg_lat,1)-1: a latency of 0 behaves like 1
    assign w_lat_load = (cfg_lat == '0) ? '0 : cfg_lat - 1'b1;

    // carry-out of the offset add is intentionally dropped
    assign w_addr_sum = s_axi4_araddr + ADDR_OFFSET;

    assign w_s_payload = {s_axi4_arid, w_addr_sum, s_axi4_arlen, s_axi4_arsize,
                          s_axi4_arburst, s_axi4_arlock, s_axi4_arprot,
                          s_axi4_arcache, s_axi4_aruser};

    // Every stored entry counts down from acceptance, not only the head,
    // so an entry stuck behind a slow head has already served its delay.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_next[i] = r_cnt[i];
            w_vld_next[i] = r_vld[i];
            if (r_vld[i] && (r_cnt[i] != '0)) begin
                w_cnt_next[i] = r_cnt[i] - 1'b1;
            end
            if (w_pop && (r_rd_ptr == c_ptr_w'(i))) begin
                w_vld_next[i] = 1'b0;
            end
            if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
                w_vld_next[i] = 1'b1;
                w_cnt_next[i] = w_lat_load;
            end
        end
    end

    // The master side is fully registered, so the head of the next cycle is
    // computed here; a request written into an empty (or emptying) FIFO
    // becomes the head directly from the slave payload.
    assign w_head_payload = (w_push && (r_wr_ptr == w_rd_next)) ? w_s_payload
                                                                : r_mem[w_rd_next];
    assign w_m_valid_next = (w_occ_next != '0) && w_vld_next[w_rd_next]
                            && (w_cnt_next[w_rd_next] == '0);

    always_ff @(posedge axi4_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_s_payload;
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_payload <= '0;
            r_vld       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_wr_ptr  <= r_wr_ptr + c_ptr_w'(w_push);
            r_rd_ptr  <= w_rd_next;
            r_occ     <= w_occ_next;
            // ready follows the registered fill level, so a pop frees a
            // slot only from the following cycle on
            r_s_ready <= (w_occ_next != c_occ_w'(DEPTH));
            r_m_valid <= w_m_valid_next;
            // payload only changes when a new head is presented, which keeps
            // it stable while a handshake is pending
            if (w_m_valid_next) begin
                r_m_payload <= w_head_payload;
            end
            r_vld     <= w_vld_next;
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign {m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize,
            m_axi4_arburst, m_axi4_arlock, m_axi4_arprot, m_axi4_arcache,
            m_axi4_aruser} = r_m_payload;

    assign m_axi4_arvalid = r_m_valid;
    assign s_axi4_arready = r_s_ready;
    assign occupancy      = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_axi4_ar_delay_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_ar_delay_fifo
// Description : Directed self-checking bench for axi4_ar_delay_fifo, with a
//               closing randomized traffic phase against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_ar_delay_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_id = '0;
    logic [31:0] s_addr = '0;
    logic [7:0]  s_len = '0;
    logic [2:0]  s_size = '0;
    logic [1:0]  s_burst = '0;
    logic        s_lock = 1'b0;
    logic [2:0]  s_prot = '0;
    logic [3:0]  s_cache = '0;
    logic [3:0]  s_user = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  m_id;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    logic [1:0]  m_burst;
    logic        m_lock;
    logic [2:0]  m_prot;
    logic [3:0]  m_cache;
    logic [3:0]  m_user;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  cfg_lat = '0;
    logic [3:0]  occ;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0]  hs_id;
    logic [31:0] hs_addr;
    logic [7:0]  hs_len;
    logic [2:0]  hs_size;
    logic [1:0]  hs_burst;
    logic        hs_lock;
    logic [2:0]  hs_prot;
    logic [3:0]  hs_cache;
    logic [3:0]  hs_user;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    axi4_ar_delay_fifo dut (
        .axi4_aclk      (clk),
        .axi4_arstn     (rst_n),
        .s_axi4_arid    (s_id),
        .s_axi4_araddr  (s_addr),
        .s_axi4_arlen   (s_len),
        .s_axi4_arsize  (s_size),
        .s_axi4_arburst (s_burst),
        .s_axi4_arlock  (s_lock),
        .s_axi4_arprot  (s_prot),
        .s_axi4_arcache (s_cache),
        .s_axi4_aruser  (s_user),
        .s_axi4_arvalid (s_valid),
        .s_axi4_arready (s_ready),
        .m_axi4_arid    (m_id),
        .m_axi4_araddr  (m_addr),
        .m_axi4_arlen   (m_len),
        .m_axi4_arsize  (m_size),
        .m_axi4_arburst (m_burst),
        .m_axi4_arlock  (m_lock),
        .m_axi4_arprot  (m_prot),
        .m_axi4_arcache (m_cache),
        .m_axi4_aruser  (m_user),
        .m_axi4_arvalid (m_valid),
        .m_axi4_arready (m_ready),
        .cfg_lat        (cfg_lat),
        .occupancy      (occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k = number of the edge (counted from now) on which the master
    // handshake completes; -1 when none within the bound
    task automatic wait_hs(output int k);
        k = -1;
        for (int n = 1; n <= 64; n++) begin
            if (m_valid && m_ready) begin
                k        = n;
                hs_id    = m_id;
                hs_addr  = m_addr;
                hs_len   = m_len;
                hs_size  = m_size;
                hs_burst = m_burst;
                hs_lock  = m_lock;
                hs_prot  = m_prot;
                hs_cache = m_cache;
                hs_user  = m_user;
                tick();
                break;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        int k;
        int acc;
        int seen;
        int acc_cnt;
        int lat_r;
        logic accepted_now;
        exp_t e;

        // ---------------- reset state ----------------
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_occ",     64'(occ),     64'd0);
        check("rst_m_addr",  64'(m_addr),  64'd0);
        tick();
        tick();
        check("rst_hold_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rel_s_ready", 64'(s_ready), 64'd1);

        // ---------------- latency 7, offset add ----------------
        m_ready = 1'b1;
        s_id = 4'd3; s_addr = 32'h0000_2000; cfg_lat = 8'd7; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        wait_hs(k);
        check("lat7_edge", 64'(k), 64'd7);
        check("lat7_addr", 64'(hs_addr), 64'h0000_3000);
        check("lat7_id",   64'(hs_id), 64'd3);

        // ---------------- address wrap, payload pass-through ----------------
        s_id = 4'd9; s_addr = 32'hFFFF_F800; cfg_lat = 8'd1;
        s_len = 8'hA5; s_size = 3'd5; s_burst = 2'd2; s_lock = 1'b1;
        s_prot = 3'd6; s_cache = 4'd9; s_user = 4'hC; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        wait_hs(k);
        check("wrap_edge",  64'(k), 64'd1);
        check("wrap_addr",  64'(hs_addr), 64'h0000_0800);
        check("pass_id",    64'(hs_id), 64'd9);
        check("pass_len",   64'(hs_len), 64'hA5);
        check("pass_size",  64'(hs_size), 64'd5);
        check("pass_burst", 64'(hs_burst), 64'd2);
        check("pass_lock",  64'(hs_lock), 64'd1);
        check("pass_prot",  64'(hs_prot), 64'd6);
        check("pass_cache", 64'(hs_cache), 64'd9);
        check("pass_user",  64'(hs_user), 64'hC);
        s_len = '0; s_size = '0; s_burst = '0; s_lock = 1'b0;
        s_prot = '0; s_cache = '0; s_user = '0;

        // ---------------- full FIFO, no accept on full edge ----------------
        m_ready = 1'b0;
        cfg_lat = 8'd0;
        acc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_id = 4'(i);
            s_addr = 32'(i * 16);
            if (s_ready) acc++;
            tick();
        end
        check("full_accepts", 64'(acc), 64'd8);
        check("full_occ",     64'(occ), 64'd8);
        check("full_s_ready", 64'(s_ready), 64'd0);
        check("full_m_valid", 64'(m_valid), 64'd1);
        check("full_head_id", 64'(m_id), 64'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("deq_s_ready", 64'(s_ready), 64'd1);
        check("deq_occ",     64'(occ), 64'd7);
        check("deq_head_id", 64'(m_id), 64'd1);
        tick();
        s_valid = 1'b0;
        check("ninth_occ",     64'(occ), 64'd8);
        check("ninth_s_ready", 64'(s_ready), 64'd0);
        m_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            check("drain_valid", 64'(m_valid), 64'd1);
            check("drain_id",    64'(m_id), 64'(j));
            tick();
        end
        check("drain_occ",   64'(occ), 64'd0);
        check("drain_empty", 64'(m_valid), 64'd0);

        // ---------------- ordering: long latency blocks short ----------------
        s_id = 4'hA; s_addr = 32'h100; cfg_lat = 8'd10; s_valid = 1'b1;
        tick();
        s_id = 4'hB; s_addr = 32'h200; cfg_lat = 8'd1;
        tick();
        s_valid = 1'b0;
        wait_hs(k);
        check("ord_a_edge", 64'(k), 64'd9);
        check("ord_a_id",   64'(hs_id), 64'hA);
        wait_hs(k);
        check("ord_b_edge", 64'(k), 64'd1);
        check("ord_b_id",   64'(hs_id), 64'hB);
        check("ord_b_addr", 64'(hs_addr), 64'h1200);

        // ---------------- reset mid-operation ----------------
        m_ready = 1'b0;
        cfg_lat = 8'd5;
        s_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s_id = 4'(i);
            tick();
        end
        s_valid = 1'b0;
        check("pre_rst_occ", 64'(occ), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_occ",     64'(occ), 64'd0);
        tick();
        tick();
        check("mid_rst_m_id",   64'(m_id), 64'd0);
        check("mid_rst_m_addr", 64'(m_addr), 64'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        check("post_rst_s_ready", 64'(s_ready), 64'd1);
        check("post_rst_occ",     64'(occ), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_valid) seen++;
            tick();
        end
        check("post_rst_no_stale", 64'(seen), 64'd0);
        s_id = 4'd5; s_addr = 32'h40; cfg_lat = 8'd2; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        wait_hs(k);
        check("post_rst_new_edge", 64'(k), 64'd2);
        check("post_rst_new_id",   64'(hs_id), 64'd5);

        // ---------------- random traffic against queue model ----------------
        acc_cnt = 0;
        s_valid = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            if (acc_cnt == 1000 && sb.size() == 0) break;
            if (!s_valid && acc_cnt < 1000 && $urandom_range(0, 2) != 0) begin
                s_id    = 4'($urandom_range(0, 15));
                s_addr  = $urandom;
                cfg_lat = 8'($urandom_range(0, 10));
                s_valid = 1'b1;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            check("rnd_occ",     64'(occ), 64'(sb.size()));
            check("rnd_s_ready", 64'(s_ready), 64'(sb.size() < 8));
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected_hs", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rnd_id",   64'(m_id), 64'(e.id));
                    check("rnd_addr", 64'(m_addr), 64'(e.addr));
                    check("rnd_min_lat", 64'((cyc + 1 - e.acc) >= e.lat), 64'd1);
                end
            end
            accepted_now = 1'b0;
            if (s_valid && s_ready) begin
                lat_r  = (cfg_lat == 8'd0) ? 1 : int'(cfg_lat);
                e.id   = s_id;
                e.addr = s_addr + 32'h1000;
                e.acc  = cyc + 1;
                e.lat  = lat_r;
                sb.push_back(e);
                acc_cnt++;
                accepted_now = 1'b1;
            end
            tick();
            if (accepted_now) s_valid = 1'b0;
        end
        check("rnd_accepted", 64'(acc_cnt), 64'd1000);
        check("rnd_drained",  64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
